// File: rtl/axi_sram_read_responder.sv
// AXI read responder: accepts one AR burst at a time, reads a synchronous SRAM
// and streams the R beats upstream through a 2-entry output buffer.
module axi_sram_read_responder #(
    parameter int IDS_W  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int MEM_AW = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDS_W-1:0]  ar_id_i,
    input  logic [ADDR_W-1:0] ar_addr_i,
    input  logic [LEN_W-1:0]  ar_len_i,
    input  logic [2:0]        ar_size_i,
    input  logic [1:0]        ar_burst_i,
    input  logic              ar_valid_i,
    output logic              ar_ready_o,
    output logic [IDS_W-1:0]  r_id_o,
    output logic [DATA_W-1:0] r_data_o,
    output logic [1:0]        r_resp_o,
    output logic              r_last_o,
    output logic              r_valid_o,
    input  logic              r_ready_i,
    output logic              sram_cs_o,
    output logic              sram_oe_o,
    output logic [MEM_AW-1:0] sram_a_o,
    input  logic [DATA_W-1:0] sram_do_i
);
    typedef enum logic {S_IDLE, S_BURST} state_e;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    state_e            state_q, state_d;
    logic              ready_en_q;
    logic [IDS_W-1:0]  id_q, id_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [1:0]        burst_q, burst_d;
    logic              err_q, err_d;
    logic [LEN_W:0]    issued_q, issued_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic              inflight_q;
    logic [DATA_W-1:0] fifo_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q, count_d;

    logic              ar_hs, pop, push, issue, req_err, wrap_bad;
    logic [2:0]        occ_next;
    logic [MEM_AW-1:0] wrap_mask, addr_next;
    logic              addr_unused;

    assign addr_unused = ^{ar_addr_i[ADDR_W-1:MEM_AW+2], ar_addr_i[1:0]};

    assign ar_ready_o = (state_q == S_IDLE) && ready_en_q;
    assign ar_hs      = ar_valid_i && ar_ready_o;
    assign r_valid_o  = (count_q != 2'd0);
    assign pop        = r_valid_o && r_ready_i;
    assign push       = inflight_q;
    assign r_last_o   = r_valid_o && (beat_q == len_q);
    assign r_id_o     = id_q;
    assign r_resp_o   = (r_valid_o && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign r_data_o   = r_valid_o ? fifo_q[rd_ptr_q] : '0;

    // Occupancy the buffer will reach once the read already in flight lands.
    assign occ_next = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue    = (state_q == S_BURST) && (issued_q <= {1'b0, len_q}) && (occ_next < 3'd2);

    // Errored bursts walk the same beat schedule but never touch the SRAM.
    assign sram_cs_o = issue && !err_q;
    assign sram_oe_o = sram_cs_o;
    assign sram_a_o  = addr_q;

    assign wrap_bad = (ar_len_i == '0) || ((ar_len_i & (ar_len_i + LEN_W'(1))) != '0);
    assign req_err  = (ar_size_i != 3'd2) || (ar_burst_i == 2'd3) ||
                      ((ar_burst_i == BURST_WRAP) && wrap_bad);

    assign wrap_mask = {{(MEM_AW-LEN_W){1'b0}}, len_q};

    always_comb begin
        addr_next = addr_q + MEM_AW'(1);
        if (burst_q == BURST_FIXED) begin
            addr_next = addr_q;
        end else if (burst_q == BURST_WRAP) begin
            addr_next = (addr_q & ~wrap_mask) | ((addr_q + MEM_AW'(1)) & wrap_mask);
        end
    end

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        addr_d   = addr_q;
        len_d    = len_q;
        burst_d  = burst_q;
        err_d    = err_q;
        issued_d = issued_q;
        beat_d   = beat_q;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        case (state_q)
            S_IDLE: begin
                if (ar_hs) begin
                    id_d     = ar_id_i;
                    addr_d   = ar_addr_i[MEM_AW+1:2];
                    len_d    = ar_len_i;
                    burst_d  = ar_burst_i;
                    err_d    = req_err;
                    issued_d = '0;
                    beat_d   = '0;
                    state_d  = S_BURST;
                end
            end
            S_BURST: begin
                if (issue) begin
                    issued_d = issued_q + (LEN_W+1)'(1);
                    addr_d   = addr_next;
                end
                if (pop) begin
                    beat_d = beat_q + LEN_W'(1);
                    if (r_last_o) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ready_en_q <= 1'b0;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            burst_q    <= '0;
            err_q      <= 1'b0;
            issued_q   <= '0;
            beat_q     <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            id_q       <= id_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            burst_q    <= burst_d;
            err_q      <= err_d;
            issued_q   <= issued_d;
            beat_q     <= beat_d;
            inflight_q <= issue;
            wr_ptr_q   <= wr_ptr_q ^ push;
            rd_ptr_q   <= rd_ptr_q ^ pop;
            count_q    <= count_d;
        end
    end

    // NOTE: buffer storage has no reset; r_data_o is gated by r_valid_o, so stale entries never show.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= err_q ? '0 : sram_do_i;
    end
endmodule

// File: tb/tb_axi_sram_read_responder.sv
// Scoreboard bench: bursts push expected beats into a queue, a monitor pops and
// compares each R handshake against a word-level SRAM reference model.
module tb_axi_sram_read_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ar_id_i = '0;
    logic [31:0] ar_addr_i = '0;
    logic [3:0]  ar_len_i = '0;
    logic [2:0]  ar_size_i = 3'd2;
    logic [1:0]  ar_burst_i = 2'd1;
    logic        ar_valid_i = 1'b0;
    logic        ar_ready_o;
    logic [7:0]  r_id_o;
    logic [31:0] r_data_o;
    logic [1:0]  r_resp_o;
    logic        r_last_o, r_valid_o;
    logic        r_ready_i = 1'b1;
    logic        sram_cs_o, sram_oe_o;
    logic [13:0] sram_a_o;
    logic [31:0] sram_do_i = '0;

    axi_sram_read_responder dut (
        .clk(clk), .rst(rst),
        .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i),
        .ar_size_i(ar_size_i), .ar_burst_i(ar_burst_i), .ar_valid_i(ar_valid_i),
        .ar_ready_o(ar_ready_o),
        .r_id_o(r_id_o), .r_data_o(r_data_o), .r_resp_o(r_resp_o),
        .r_last_o(r_last_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
        .sram_cs_o(sram_cs_o), .sram_oe_o(sram_oe_o), .sram_a_o(sram_a_o),
        .sram_do_i(sram_do_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] mem [16384];
    int          checks = 0;
    int          errors = 0;
    int          rdy_mode = 0;
    bit          cur_err = 1'b0;
    int          pop_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous SRAM: data appears the cycle after the access edge.
    always @(posedge clk) if (sram_cs_o) sram_do_i <= mem[sram_a_o];

    initial begin : ready_driver
        bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int idx = 0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1:       r_ready_i = 1'($urandom_range(0, 1));
                2:       begin r_ready_i = pat[idx % 6]; idx++; end
                default: r_ready_i = 1'b1;
            endcase
        end
    end

    initial begin : monitor
        bit          stall_prev = 1'b0, last_prev = 1'b0;
        logic [31:0] s_data;
        logic        s_last;
        logic [1:0]  s_resp;
        int          outstanding = 0;
        beat_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                stall_prev = 1'b0;
                last_prev = 1'b0;
                outstanding = 0;
            end else begin
                if (last_prev) check("ar_ready_after_last", ar_ready_o, 1);
                last_prev = 1'b0;
                if (stall_prev) begin
                    check("stall_valid", r_valid_o, 1);
                    check("stall_data", r_data_o, s_data);
                    check("stall_last", r_last_o, s_last);
                    check("stall_resp", r_resp_o, s_resp);
                end
                if (cur_err) check("err_no_cs", sram_cs_o, 0);
                check("oe_eq_cs", sram_oe_o, sram_cs_o);
                if (sram_cs_o) outstanding++;
                if (r_valid_o && r_ready_i && !cur_err) outstanding--;
                if (sram_cs_o) check("buffer_bound", outstanding <= 2, 1);
                if (r_valid_o && r_ready_i) begin
                    pop_total++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", r_valid_o, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("r_id", r_id_o, e.id);
                        check("r_data", r_data_o, e.data);
                        check("r_resp", r_resp_o, e.resp);
                        check("r_last", r_last_o, e.last);
                        last_prev = e.last;
                    end
                end
                stall_prev = r_valid_o && !r_ready_i;
                s_data = r_data_o;
                s_last = r_last_o;
                s_resp = r_resp_o;
            end
        end
    end

    // Drives one AR request and, at the handshake, pushes the expected beats.
    task automatic do_ar(input logic [7:0] id, input logic [31:0] addr, input int len,
                         input logic [2:0] size, input logic [1:0] burst);
        int          waited = 0;
        int          n = len + 1;
        int unsigned start = (addr >> 2) & 32'h3FFF;
        int unsigned w;
        bit          err;
        beat_t       b;
        err = (size != 3'd2) || (burst == 2'd3) ||
              (burst == 2'd2 && !(n == 2 || n == 4 || n == 8 || n == 16));
        @(posedge clk); #1;
        ar_id_i = id; ar_addr_i = addr; ar_len_i = 4'(len);
        ar_size_i = size; ar_burst_i = burst; ar_valid_i = 1'b1;
        forever begin
            @(negedge clk);
            if (ar_ready_o) break;
            waited++;
            if (waited > 400) begin
                check("ar_handshake_timeout", ar_ready_o, 1);
                ar_valid_i = 1'b0;
                return;
            end
        end
        cur_err = err;
        for (int i = 0; i <= len; i++) begin
            case (burst)
                2'd0:    w = start;
                2'd2:    w = (start - start % n) + (start % n + i) % n;
                default: w = (start + i) % 16384;
            endcase
            b.id = id;
            b.data = err ? 32'h0 : mem[w];
            b.resp = err ? 2'd2 : 2'd0;
            b.last = (i == len);
            exp_q.push_back(b);
        end
        @(posedge clk); #1;
        ar_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : stimulus
        int start_pops;
        int n;
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        mem[16'h10] = 32'hDEADBEEF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ar_ready", ar_ready_o, 0);
        check("rst_r_valid", r_valid_o, 0);
        check("rst_r_last", r_last_o, 0);
        check("rst_r_data", r_data_o, 0);
        check("rst_r_id", r_id_o, 0);
        check("rst_r_resp", r_resp_o, 0);
        check("rst_sram_cs", sram_cs_o, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("ar_ready_after_rst", ar_ready_o, 1);

        // Single read and its two-cycle latency.
        do_ar(8'h5A, 32'h40, 0, 3'd2, 2'd1);
        @(negedge clk); check("lat_c1_valid", r_valid_o, 0);
        @(negedge clk); check("lat_c2_valid", r_valid_o, 0);
        @(negedge clk); check("lat_c3_valid", r_valid_o, 1);
        wait_idle(50);

        // INCR stream with no bubbles.
        do_ar(8'h21, 32'h100, 3, 3'd2, 2'd1);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("incr_valid", r_valid_o, 1);
            check("incr_last", r_last_o, i == 3);
        end
        wait_idle(50);

        // Backpressure pattern on the same burst.
        rdy_mode = 2;
        do_ar(8'h22, 32'h100, 3, 3'd2, 2'd1);
        wait_idle(100);
        rdy_mode = 0;

        do_ar(8'h31, 32'h18, 3, 3'd2, 2'd2);
        wait_idle(50);
        do_ar(8'h32, 32'h20, 2, 3'd2, 2'd0);
        wait_idle(50);
        do_ar(8'h33, 32'h0000_FFF8, 3, 3'd2, 2'd1);
        wait_idle(50);

        // Error bursts.
        do_ar(8'h41, 32'h80, 1, 3'd1, 2'd1);
        wait_idle(50);
        do_ar(8'h42, 32'h80, 1, 3'd2, 2'd3);
        wait_idle(50);
        do_ar(8'h43, 32'h80, 2, 3'd2, 2'd2);
        wait_idle(50);

        // Randomized bursts under random backpressure.
        rdy_mode = 1;
        for (int k = 0; k < 40; k++) begin
            logic [2:0] sz;
            sz = ($urandom_range(0, 9) < 8) ? 3'd2 : 3'($urandom_range(0, 7));
            do_ar(8'($urandom), $urandom, int'($urandom_range(0, 15)), sz, 2'($urandom_range(0, 3)));
        end
        wait_idle(2000);
        rdy_mode = 0;

        // Reset in the middle of an 8-beat burst.
        do_ar(8'h77, 32'h200, 7, 3'd2, 2'd1);
        start_pops = pop_total;
        n = 0;
        while (pop_total < start_pops + 2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("midburst_two_beats", pop_total >= start_pops + 2, 1);
        rst = 1'b1;
        cur_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst_r_valid", r_valid_o, 0);
        check("midrst_ar_ready", ar_ready_o, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_ar_ready_release", ar_ready_o, 1);
        do_ar(8'h78, 32'h40, 0, 3'd2, 2'd1);
        wait_idle(50);

        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
